// File: rtl/screen_image_painter.sv
// screen_image_painter
// Streams an IMG_W x IMG_H image out of a fixed-latency ROM into a framebuffer.
// ROM reads are issued ahead of the framebuffer writes. A small skid FIFO
// absorbs framebuffer back-pressure, so a stalled write never loses a pixel.
// After the first full frame, a fresh key press or an optional timeout
// raises a one-cycle request to leave the screen.

`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 17
`endif

module screen_image_painter #(
    parameter int  IMG_W       = 320,
    parameter int  IMG_H       = 240,
    parameter int  PIX_W       = 12,
    parameter int  ROM_LAT     = 1,
    parameter int  KEYS        = 26,
    parameter int  CONTINUOUS  = 1,
    parameter int  TIMEOUT_CYC = 0,
    parameter int  AUTO_START  = 1,
    localparam int NPIX        = IMG_W * IMG_H,
    localparam int AW          = $clog2(NPIX)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [KEYS-1:0]             key_status,
    input  logic                        fb_ready,
    output logic [AW-1:0]               rom_addr,
    input  logic [PIX_W-1:0]            rom_data,
    output logic                        fb_we,
    output logic [`DISP_ADDR_WIDTH-1:0] fb_addr,
    output logic [31:0]                 fb_wdata,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        screen_done
);

    localparam int              FBW       = `DISP_ADDR_WIDTH;
    localparam int              DEPTH     = ROM_LAT + 1;
    localparam int              PTRW      = $clog2(DEPTH);
    localparam int              CNTW      = $clog2(DEPTH + 1);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(NPIX - 1);
    localparam logic [PTRW-1:0] LAST_PTR  = PTRW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PAINT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    // read issue side
    logic [AW-1:0]      r_rom_addr;
    logic               r_issue_done;
    logic [ROM_LAT-1:0] r_pipe_vld;
    logic [AW-1:0]      r_pipe_addr [ROM_LAT];

    // skid FIFO
    logic [AW-1:0]      r_fifo_addr [DEPTH];
    logic [PIX_W-1:0]   r_fifo_data [DEPTH];
    logic [PTRW-1:0]    r_wr_ptr;
    logic [PTRW-1:0]    r_rd_ptr;
    logic [CNTW-1:0]    r_fifo_cnt;

    // leave-screen logic
    logic [KEYS-1:0]    r_key_prev;
    logic               r_armed;
    logic               r_painted;

    logic               w_fifo_nempty;
    logic               w_pop;
    logic               w_capture;
    logic               w_issue;
    logic               w_last_wr;
    logic               w_key_edge;
    logic               w_key_hit;
    logic               w_timeout_hit;
    logic               w_screen_done;
    logic [CNTW-1:0]    w_inflight;
    logic [CNTW:0]      w_outstanding;

    // Count ROM reads still travelling through the latency pipeline.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            w_inflight = w_inflight + CNTW'(r_pipe_vld[i]);
        end
    end

    // The entry popped this cycle frees its slot. Crediting it keeps one
    // write per cycle with fb_ready high, and capacity is never exceeded.
    assign w_outstanding = {1'b0, w_inflight} + {1'b0, r_fifo_cnt} - (CNTW + 1)'(w_pop);
    assign w_issue       = (r_state == ST_PAINT) && !r_issue_done && !start &&
                           (w_outstanding < (CNTW + 1)'(DEPTH));
    assign w_capture     = r_pipe_vld[ROM_LAT-1];

    assign w_fifo_nempty = (r_fifo_cnt != '0);
    assign w_pop         = w_fifo_nempty & fb_ready;
    assign w_last_wr     = w_pop && (r_fifo_addr[r_rd_ptr] == LAST_ADDR);

    assign rom_addr      = r_rom_addr;
    assign fb_we         = w_fifo_nempty;
    assign fb_addr       = w_fifo_nempty ? FBW'(r_fifo_addr[r_rd_ptr]) : '0;
    assign fb_wdata      = w_fifo_nempty ? 32'(r_fifo_data[r_rd_ptr]) : '0;
    assign busy          = (r_state == ST_PAINT);
    assign frame_done    = w_last_wr;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; start always (re)enters PAINT from any state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start || (AUTO_START != 0)) begin
                    w_state_next = ST_PAINT;
                end
            end
            ST_PAINT: begin
                if (!start && w_last_wr && (CONTINUOUS == 0)) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (start) begin
                    w_state_next = ST_PAINT;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ROM address counter: one step per issued read. It wraps in continuous mode
    // and stops after the last pixel in single-frame mode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_addr   <= '0;
            r_issue_done <= 1'b0;
        end else if (start) begin
            r_rom_addr   <= '0;
            r_issue_done <= 1'b0;
        end else if (w_issue) begin
            if (r_rom_addr == LAST_ADDR) begin
                r_rom_addr   <= '0;
                r_issue_done <= (CONTINUOUS == 0);
            end else begin
                r_rom_addr   <= r_rom_addr + 1'b1;
            end
        end
    end

    // Latency pipeline: tags each read with its address. The tag reaches the
    // last stage in the same cycle the ROM presents the data. start drops it all.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                r_pipe_addr[i] <= '0;
            end
        end else begin
            r_pipe_vld[0]  <= w_issue;
            r_pipe_addr[0] <= r_rom_addr;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_pipe_vld[i]  <= start ? 1'b0 : r_pipe_vld[i-1];
                r_pipe_addr[i] <= r_pipe_addr[i-1];
            end
        end
    end

    // FIFO pointers and occupancy. start empties the FIFO, which drops fb_we on the next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else if (start) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_capture) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            r_fifo_cnt <= r_fifo_cnt + CNTW'(w_capture) - CNTW'(w_pop);
        end
    end

    // FIFO storage. The head entry stays put while the framebuffer stalls.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_fifo_addr[r_wr_ptr] <= r_pipe_addr[ROM_LAT-1];
            r_fifo_data[r_wr_ptr] <= rom_data;
        end
    end

    assign w_key_edge    = |(key_status & ~r_key_prev);
    assign w_key_hit     = r_armed & w_key_edge;
    assign w_screen_done = w_key_hit | w_timeout_hit;
    assign screen_done   = w_screen_done;

    // Key history and arming. A new request needs all keys released after
    // the first frame, and the arm is consumed by each request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key_prev <= '0;
            r_armed    <= 1'b0;
            r_painted  <= 1'b0;
        end else begin
            r_key_prev <= key_status;
            if (w_last_wr) begin
                r_painted <= 1'b1;
            end
            if (w_screen_done) begin
                r_armed <= 1'b0;
            end else if (r_painted && (key_status == '0)) begin
                r_armed <= 1'b1;
            end
        end
    end

    generate
        if (TIMEOUT_CYC > 0) begin : g_timer
            localparam int TW = $clog2(TIMEOUT_CYC + 1);
            logic [TW-1:0] r_timer;
            logic          r_timer_run;

            // Timeout counter: starts on the first completed frame, reads k on
            // the k-th cycle after it, and stops at the first leave request.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_timer     <= '0;
                    r_timer_run <= 1'b0;
                end else if (w_last_wr && !r_painted) begin
                    r_timer     <= TW'(1);
                    r_timer_run <= 1'b1;
                end else if (r_timer_run) begin
                    if (w_screen_done) begin
                        r_timer_run <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
            end

            assign w_timeout_hit = r_timer_run && (r_timer == TW'(TIMEOUT_CYC));
        end else begin : g_no_timer
            assign w_timeout_hit = 1'b0;
        end
    endgenerate

endmodule

// File: doc/screen_image_painter.md
SCREEN_IMAGE_PAINTER -- requirements
Module: screen_image_painter

Interface
REQ-001 Parameter IMG_W, default 320, image width in pixels.
REQ-002 Parameter IMG_H, default 240, image height in pixels.
REQ-003 Parameter PIX_W, default 12, ROM pixel width; fb_wdata = zero-extended rom_data.
REQ-004 Parameter ROM_LAT, default 1, ROM read latency in cycles (1..4).
REQ-005 Parameter KEYS, default 26, key_status width.
REQ-006 Parameter CONTINUOUS, default 1; 1 = repaint forever, 0 = paint one frame then stop.
REQ-007 Parameter TIMEOUT_CYC, default 0; cycles after first completed frame before auto screen_done; 0 = disabled.
REQ-008 Parameter AUTO_START, default 1; 1 = begin painting on the first cycle after reset release.
REQ-009 Derived NPIX = IMG_W*IMG_H; AW = clog2(NPIX).
REQ-010 clk  input  1  single clock, all logic on rising edge.
REQ-011 reset_n  input  1  asynchronous, active-low reset.
REQ-012 start  input  1  one-cycle pulse; (re)start painting from pixel 0.
REQ-013 key_status  input  KEYS  level key states, 1 = pressed.
REQ-014 fb_ready  input  1  framebuffer accepts a write this cycle.
REQ-015 rom_addr  output  AW  image ROM read address.
REQ-016 rom_data  input  PIX_W  ROM data, valid ROM_LAT cycles after rom_addr.
REQ-017 fb_we  output  1  write strobe; a write completes when fb_we & fb_ready.
REQ-018 fb_addr  output  `DISP_ADDR_WIDTH  framebuffer pixel address.
REQ-019 fb_wdata  output  32  {zeros, pixel}.
REQ-020 busy  output  1  high in PAINT state.
REQ-021 frame_done  output  1  one-cycle pulse when pixel NPIX-1 is written.
REQ-022 screen_done  output  1  one-cycle pulse requesting leave-screen.

Function
REQ-023 States IDLE, PAINT, HOLD. IDLE->PAINT on start (or after reset if AUTO_START). PAINT->PAINT on frame end if CONTINUOUS, else PAINT->HOLD. HOLD->PAINT on start.
REQ-024 Read issue: rom_addr advances 0..NPIX-1 by one per issued read; wraps to 0 in CONTINUOUS; no read issued when in-flight reads + skid occupancy = ROM_LAT+1.
REQ-025 Skid FIFO depth ROM_LAT+1 captures rom_data with its address; fb_we = FIFO non-empty; FIFO head pops only on fb_we & fb_ready; fb_addr/fb_wdata stable while fb_we & !fb_ready.
REQ-026 Writes occur in strictly increasing address order, no pixel skipped or duplicated; full throughput (one write per cycle) when fb_ready held high.
REQ-027 start during PAINT: in-flight reads discarded, FIFO flushed, fb_we low next cycle, issue restarts at 0 next cycle.
REQ-028 frame_done pulses on the cycle the write of address NPIX-1 completes; painted flag set then, cleared only by reset.
REQ-029 Key edge: key_prev registered every cycle; edge = |(key_status & ~key_prev).
REQ-030 armed sets when painted=1 and key_status==0; screen_done = armed & edge; armed clears the cycle after screen_done (re-arm needs full release).
REQ-031 Timeout: counter starts at first frame_done, screen_done pulses once at count TIMEOUT_CYC; key and timeout in same cycle give one pulse; either pulse stops the timer.

Reset
REQ-032 On reset_n low: state IDLE, rom_addr 0, FIFO empty, fb_we 0, fb_addr 0, fb_wdata 0, busy 0, frame_done 0, screen_done 0, key_prev 0, armed 0, painted 0, timer 0; reset mid-frame discards all pending writes.

Verification
REQ-033 IMG_W=4, IMG_H=2, ROM_LAT=2, fb_ready=1, ROM returns addr -> fb addresses 0..7 consecutive, data = addr, frame_done on write of 7, then wrap to 0.
REQ-034 Same, fb_ready toggled pseudo-randomly -> exactly 0..7 in order, no loss/duplicate, fb_addr stable while stalled.
REQ-035 CONTINUOUS=0 -> after address 7 fb_we stays 0, busy 0; start pulse -> repaint from 0.
REQ-036 Key held through reset and first frame -> no screen_done; release all, press key 3 -> single screen_done pulse; holding key -> no further pulse.
REQ-037 TIMEOUT_CYC=10, no keys -> screen_done exactly 10 cycles after frame_done, once.
REQ-038 start at pixel 5, and reset_n low at pixel 3 -> writes restart at 0 (start) / all outputs zero while reset (reset).
